// File: rtl/regfile_commit_arbiter_if.sv
// regfile_commit_arbiter_if
//   Bundles the dual-commit input side and the register-file write port of
//   regfile_commit_arbiter.
//   master : ROB / register-file side (drives commits, rdy_in, rob_clear)
//   slave  : the arbiter (drives in_ready, write port and count)
//   Signals: rdy_in, rob_clear, c0_*/c1_* commit slots (c0 older), in_ready,
//            set_reg_id / set_val / set_reg_on_rob_id write port, count.
interface regfile_commit_arbiter_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ROB_W = 4
);
   logic                         rdy_in;
   logic                         rob_clear;
   logic                         c0_valid;
   logic [4:0]                   c0_reg;
   logic [31:0]                  c0_val;
   logic [ROB_W-1:0]             c0_rob;
   logic                         c1_valid;
   logic [4:0]                   c1_reg;
   logic [31:0]                  c1_val;
   logic [ROB_W-1:0]             c1_rob;
   logic                         in_ready;
   logic [4:0]                   set_reg_id;
   logic [31:0]                  set_val;
   logic [ROB_W-1:0]             set_reg_on_rob_id;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (
      output rdy_in, rob_clear,
      output c0_valid, c0_reg, c0_val, c0_rob,
      output c1_valid, c1_reg, c1_val, c1_rob,
      input  in_ready, set_reg_id, set_val, set_reg_on_rob_id, count
   );

   modport slave (
      input  rdy_in, rob_clear,
      input  c0_valid, c0_reg, c0_val, c0_rob,
      input  c1_valid, c1_reg, c1_val, c1_rob,
      output in_ready, set_reg_id, set_val, set_reg_on_rob_id, count
   );
endinterface

// File: rtl/regfile_commit_arbiter.sv
// regfile_commit_arbiter
//   Absorbs up to two ROB commits per cycle into an in-order FIFO and drains
//   one architectural register write per cycle onto the register file's single
//   write port. Writes are held (not popped) during rob_clear cycles.
//   Ports:
//     clk_in  : system clock
//     rst_in  : asynchronous active-high reset, empties the FIFO
//     arb_if  : slave side of regfile_commit_arbiter_if (commits in, write out)
//   Optional feature macro: REGFILE_ARB_COALESCE_EN
//     When defined, a same-cycle c0/c1 pair targeting the same nonzero register
//     enqueues only c1 (the c0 write is dead).
module regfile_commit_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ROB_W = 4
) (
   input logic                      clk_in,
   input logic                      rst_in,
   regfile_commit_arbiter_if.slave  arb_if
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [4:0]       rid;
      logic [31:0]      val;
      logic [ROB_W-1:0] rob;
   } entry_t;

   entry_t            mem_q [DEPTH];
   logic [PtrW-1:0]   head_q, head_d;
   logic [PtrW-1:0]   tail_q, tail_d;
   logic [CntW-1:0]   count_q, count_d;

   logic              ready;
   logic              push0, push1, pop;
   logic [PtrW-1:0]   tail1;
   logic [CntW-1:0]   free_cnt;

   // Readiness is based on the current occupancy only; a same-cycle pop does
   // not make room, which keeps in_ready free of any rob_clear dependency.
   assign free_cnt = CntW'(DEPTH) - count_q;
   assign ready    = arb_if.rdy_in && (free_cnt >= CntW'(2));

   always_comb begin
      push0 = ready && arb_if.c0_valid && (arb_if.c0_reg != 5'd0);
      push1 = ready && arb_if.c1_valid && (arb_if.c1_reg != 5'd0);
`ifdef REGFILE_ARB_COALESCE_EN
      // Younger write to the same register supersedes the older one.
      if (push0 && push1 && (arb_if.c0_reg == arb_if.c1_reg)) begin
         push0 = 1'b0;
      end
`endif
      pop    = (count_q != '0) && arb_if.rdy_in && !arb_if.rob_clear;
      tail1  = push0 ? tail_q + PtrW'(1) : tail_q;
      tail_d = tail_q + PtrW'(push0) + PtrW'(push1);
      head_d = pop ? head_q + PtrW'(1) : head_q;
      count_d = count_q + CntW'(push0) + CntW'(push1) - CntW'(pop);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the output is masked whenever count is zero.
   always_ff @(posedge clk_in) begin
      if (push0) begin
         mem_q[tail_q] <= '{rid: arb_if.c0_reg, val: arb_if.c0_val, rob: arb_if.c0_rob};
      end
      if (push1) begin
         mem_q[tail1] <= '{rid: arb_if.c1_reg, val: arb_if.c1_val, rob: arb_if.c1_rob};
      end
   end

   always_comb begin
      arb_if.set_reg_id        = '0;
      arb_if.set_val           = '0;
      arb_if.set_reg_on_rob_id = '0;
      if (count_q != '0) begin
         arb_if.set_reg_id        = mem_q[head_q].rid;
         arb_if.set_val           = mem_q[head_q].val;
         arb_if.set_reg_on_rob_id = mem_q[head_q].rob;
      end
   end

   assign arb_if.in_ready = ready;
   assign arb_if.count    = count_q;
endmodule

// File: tb/tb_regfile_commit_arbiter.sv
// tb_regfile_commit_arbiter
//   Directed bench for regfile_commit_arbiter (DEPTH=4, ROB_W=4): a table of
//   per-cycle input/expected-output records plus hand-written sequences for
//   rob_clear hold, rdy_in stall, full FIFO, same-register pair and async reset.
module tb_regfile_commit_arbiter;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk_in = ~clk_in;

   regfile_commit_arbiter_if #(.DEPTH(4), .ROB_W(4)) bus ();

   regfile_commit_arbiter #(.DEPTH(4), .ROB_W(4)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .arb_if (bus)
   );

   typedef struct {
      logic        rdy, clr;
      logic        c0v;
      logic [4:0]  c0r;
      logic [31:0] c0d;
      logic [3:0]  c0b;
      logic        c1v;
      logic [4:0]  c1r;
      logic [31:0] c1d;
      logic [3:0]  c1b;
      logic        e_rdy;
      logic [4:0]  e_id;
      logic [31:0] e_val;
      logic [3:0]  e_rob;
      logic [2:0]  e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic rdy, clr,
                               input logic c0v, input logic [4:0] c0r,
                               input logic [31:0] c0d, input logic [3:0] c0b,
                               input logic c1v, input logic [4:0] c1r,
                               input logic [31:0] c1d, input logic [3:0] c1b,
                               input logic er, input logic [4:0] eid,
                               input logic [31:0] ev, input logic [3:0] eb,
                               input logic [2:0] ec);
      vec_t v;
      v.rdy = rdy; v.clr = clr;
      v.c0v = c0v; v.c0r = c0r; v.c0d = c0d; v.c0b = c0b;
      v.c1v = c1v; v.c1r = c1r; v.c1d = c1d; v.c1b = c1b;
      v.e_rdy = er; v.e_id = eid; v.e_val = ev; v.e_rob = eb; v.e_cnt = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive on the falling edge, compare 2 ns later (well before the rising edge).
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk_in);
      bus.rdy_in = v.rdy;     bus.rob_clear = v.clr;
      bus.c0_valid = v.c0v;   bus.c0_reg = v.c0r; bus.c0_val = v.c0d; bus.c0_rob = v.c0b;
      bus.c1_valid = v.c1v;   bus.c1_reg = v.c1r; bus.c1_val = v.c1d; bus.c1_rob = v.c1b;
      #2;
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(v.e_rdy));
      chk({tag, ".set_reg_id"}, 32'(bus.set_reg_id), 32'(v.e_id));
      chk({tag, ".set_val"}, bus.set_val, v.e_val);
      chk({tag, ".set_rob"}, 32'(bus.set_reg_on_rob_id), 32'(v.e_rob));
      chk({tag, ".count"}, 32'(bus.count), 32'(v.e_cnt));
   endtask

   // Shorthands: idle cycle, and the r1/r2 dual-commit pair.
   function automatic vec_t idle(input logic er, input logic [4:0] eid,
                                 input logic [31:0] ev, input logic [3:0] eb,
                                 input logic [2:0] ec);
      return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, er, eid, ev, eb, ec);
   endfunction

   function automatic vec_t pair12(input logic er, input logic [4:0] eid,
                                   input logic [31:0] ev, input logic [3:0] eb,
                                   input logic [2:0] ec);
      return mk(1, 0, 1, 1, 32'h11, 0, 1, 2, 32'h22, 1, er, eid, ev, eb, ec);
   endfunction

   vec_t tab [16];

   initial begin
      bus.rdy_in = 1'b1; bus.rob_clear = 1'b0;
      bus.c0_valid = 1'b0; bus.c0_reg = '0; bus.c0_val = '0; bus.c0_rob = '0;
      bus.c1_valid = 1'b0; bus.c1_reg = '0; bus.c1_val = '0; bus.c1_rob = '0;

      // Single commit, dual-commit burst with back-pressure, x0 drop.
      tab[0]  = mk(1, 0, 1, 5, 32'hDEADBEEF, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      tab[1]  = idle(1, 5, 32'hDEADBEEF, 3, 1);
      tab[2]  = idle(1, 0, 0, 0, 0);
      tab[3]  = pair12(1, 0, 0, 0, 0);
      tab[4]  = pair12(1, 1, 32'h11, 0, 2);
      tab[5]  = pair12(0, 2, 32'h22, 1, 3);
      tab[6]  = pair12(1, 1, 32'h11, 0, 2);
      tab[7]  = pair12(0, 2, 32'h22, 1, 3);
      tab[8]  = pair12(1, 1, 32'h11, 0, 2);
      tab[9]  = idle(0, 2, 32'h22, 1, 3);
      tab[10] = idle(1, 1, 32'h11, 0, 2);
      tab[11] = idle(1, 2, 32'h22, 1, 1);
      tab[12] = idle(1, 0, 0, 0, 0);
      tab[13] = mk(1, 0, 1, 0, 32'h99, 4, 1, 7, 32'h77, 5, 1, 0, 0, 0, 0);
      tab[14] = idle(1, 7, 32'h77, 5, 1);
      tab[15] = idle(1, 0, 0, 0, 0);

      // Reset state (in_ready follows rdy_in while in reset).
      #2;
      chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst.set_reg_id", 32'(bus.set_reg_id), 32'd0);
      chk("rst.count", 32'(bus.count), 32'd0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b0;

      for (int i = 0; i < 16; i++) apply(tab[i], $sformatf("row%0d", i));

      // rob_clear holds r9 at the head for one extra cycle.
      apply(mk(1, 0, 1, 9, 32'h909, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0), "clr0");
      apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h909, 6, 1), "clr1");
      apply(idle(1, 9, 32'h909, 6, 1), "clr2");
      apply(idle(1, 0, 0, 0, 0), "clr3");

      // rdy_in low for 3 cycles with 2 queued; presented commits are ignored.
      apply(mk(1, 0, 1, 3, 32'h33, 7, 1, 6, 32'h66, 8, 1, 0, 0, 0, 0), "stl0");
      for (int i = 0; i < 3; i++)
         apply(mk(0, 0, 1, 8, 32'h88, 9, 1, 10, 32'hAA, 10, 0, 3, 32'h33, 7, 2),
               $sformatf("stl%0d", i + 1));
      apply(idle(1, 3, 32'h33, 7, 2), "stl4");
      apply(idle(1, 6, 32'h66, 8, 1), "stl5");
      apply(idle(1, 0, 0, 0, 0), "stl6");

      // Fill to DEPTH: a push cycle under rob_clear reaches count 4.
      apply(mk(1, 0, 1, 12, 32'hC0, 1, 1, 13, 32'hD0, 2, 1, 0, 0, 0, 0), "full0");
      apply(mk(1, 1, 1, 12, 32'hC1, 3, 1, 13, 32'hD1, 4, 1, 12, 32'hC0, 1, 2), "full1");
      apply(idle(0, 12, 32'hC0, 1, 4), "full2");
      apply(idle(0, 13, 32'hD0, 2, 3), "full3");
      apply(idle(1, 12, 32'hC1, 3, 2), "full4");
      apply(idle(1, 13, 32'hD1, 4, 1), "full5");
      apply(idle(1, 0, 0, 0, 0), "full6");

      // Same register on both slots.
      apply(mk(1, 0, 1, 4, 32'd1, 2, 1, 4, 32'd2, 3, 1, 0, 0, 0, 0), "same0");
`ifdef REGFILE_ARB_COALESCE_EN
      apply(idle(1, 4, 32'd2, 3, 1), "same1");
`else
      apply(idle(1, 4, 32'd1, 2, 2), "same1");
      apply(idle(1, 4, 32'd2, 3, 1), "same2");
`endif
      apply(idle(1, 0, 0, 0, 0), "same3");

      // Async reset mid-drain empties the FIFO immediately.
      apply(mk(1, 0, 1, 10, 32'hA, 1, 1, 11, 32'hB, 2, 1, 0, 0, 0, 0), "ar0");
      apply(idle(1, 10, 32'hA, 1, 2), "ar1");
      #1 rst_in = 1'b1;
      #1;
      chk("ar2.set_reg_id", 32'(bus.set_reg_id), 32'd0);
      chk("ar2.set_val", bus.set_val, 32'd0);
      chk("ar2.set_rob", 32'(bus.set_reg_on_rob_id), 32'd0);
      chk("ar2.count", 32'(bus.count), 32'd0);
      chk("ar2.in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk_in);
      rst_in = 1'b0;
      apply(idle(1, 0, 0, 0, 0), "ar3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
